// File: rtl/handshake_cdc_tx_if.sv
// handshake_cdc_tx_if: word-transfer bundle between a source-domain user, the toggle sender and its remote receiver
// Ports: en, din, rx_ack_toggle flow into the sender (slave); busy, done, dropped, tx_data, tx_req_toggle flow out
interface handshake_cdc_tx_if #(parameter int WIDTH = 32);
    logic             en;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic             dropped;
    logic [WIDTH-1:0] tx_data;
    logic             tx_req_toggle;
    logic             rx_ack_toggle;
    modport master (output en, din, rx_ack_toggle, input busy, done, dropped, tx_data, tx_req_toggle);
    modport slave (input en, din, rx_ack_toggle, output busy, done, dropped, tx_data, tx_req_toggle);
endinterface

// File: rtl/handshake_cdc_tx.sv
// handshake_cdc_tx: sending endpoint of a toggle req/ack handshake carrying a WIDTH-bit word to another clock domain
// Ports: clk, rst (async, active high); b.en/b.din request a send; b.busy, b.done, b.dropped report status;
//        b.tx_data/b.tx_req_toggle go to the remote domain; b.rx_ack_toggle comes back asynchronously
module handshake_cdc_tx #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 3
) (
    input logic               clk,
    input logic               rst,
    handshake_cdc_tx_if.slave b
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, ACKED} state_t;
    state_t state;
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] ack_sync;
    logic ack_pending;
    // the receiver still owes an echo of the current request toggle
    assign ack_pending = ack_sync[SYNC_STAGES-1] ^ b.tx_req_toggle;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            ack_sync        <= '0;
            b.busy          <= 1'b0;
            b.done          <= 1'b0;
            b.dropped       <= 1'b0;
            b.tx_data       <= {WIDTH{1'b0}};
            b.tx_req_toggle <= 1'b0;
        end else begin
            ack_sync  <= {ack_sync[SYNC_STAGES-2:0], b.rx_ack_toggle};
            b.done    <= 1'b0;
            b.dropped <= 1'b0;
            case (state)
                IDLE: begin
                    // a stale ack (remote not reset) blocks sending until it echoes the current toggle
                    if (b.en && ack_pending) b.dropped <= 1'b1;
                    else if (b.en) begin
                        b.tx_data       <= b.din;
                        b.tx_req_toggle <= ~b.tx_req_toggle;
                        b.busy          <= 1'b1;
                        state           <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // done wins over an en in the ack cycle so done and dropped never coincide
                    if (!ack_pending) begin
                        b.done <= 1'b1;
                        state  <= ACKED;
                    end else if (b.en) b.dropped <= 1'b1;
                end
                ACKED: begin
                    // busy stays high through the done cycle, so en there is refused
                    b.busy    <= 1'b0;
                    b.dropped <= b.en;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_handshake_cdc_tx.sv
// tb_handshake_cdc_tx: directed and randomized checks of handshake_cdc_tx against a transaction-count model
module tb_handshake_cdc_tx;
    logic clk = 1'b0;
    logic rclk = 1'b0;
    logic rst = 1'b1;
    logic auto_mode = 1'b0;
    logic ack_man = 1'b0;
    logic ack_auto, r1, r2;
    int vectors = 0;
    int errors = 0;
    int sent, acked;
    logic just_done;
    logic [2:0] h;
    logic [31:0] m_data;
    logic m_done, m_drop;
    logic [31:0] q_rx[$];
    logic [31:0] q_exp[$];
    always #3 clk = ~clk;
    initial begin
        #1;
        forever #7 rclk = ~rclk;
    end
    handshake_cdc_tx_if #(.WIDTH(32)) bus ();
    assign bus.rx_ack_toggle = auto_mode ? ack_auto : ack_man;
    handshake_cdc_tx #(.WIDTH(32), .SYNC_STAGES(3)) dut (.clk(clk), .rst(rst), .b(bus));
    always @(posedge rclk or posedge rst) begin
        if (rst) begin
            r1       <= 1'b0;
            r2       <= 1'b0;
            ack_auto <= 1'b0;
        end else if (auto_mode) begin
            r1 <= bus.tx_req_toggle;
            r2 <= r1;
            if (r2 != ack_auto) begin
                q_rx.push_back(bus.tx_data);
                ack_auto <= r2;
            end
        end
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        sent = 0;
        acked = 0;
        just_done = 1'b0;
        h = '0;
        m_data = '0;
        m_done = 1'b0;
        m_drop = 1'b0;
    endtask
    task automatic step(input logic e, input logic [31:0] d);
        logic seen;
        bus.en = e;
        bus.din = d;
        @(posedge clk);
        seen = h[2];
        h = {h[1:0], bus.rx_ack_toggle};
        m_done = 1'b0;
        m_drop = 1'b0;
        if (just_done) begin
            just_done = 1'b0;
            m_drop = e;
        end else if (sent != acked) begin
            if (seen == sent[0]) begin
                acked++;
                m_done = 1'b1;
                just_done = 1'b1;
            end else m_drop = e;
        end else if (e) begin
            if (seen == sent[0]) begin
                sent++;
                m_data = d;
                q_exp.push_back(d);
            end else m_drop = 1'b1;
        end
        #1;
        check("busy", 32'(bus.busy), 32'((sent != acked) || just_done));
        check("done", 32'(bus.done), 32'(m_done));
        check("dropped", 32'(bus.dropped), 32'(m_drop));
        check("tx_data", bus.tx_data, m_data);
        check("tx_req_toggle", 32'(bus.tx_req_toggle), 32'(sent[0]));
    endtask
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.en = 1'b0;
        model_reset();
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dropped", 32'(bus.dropped), 32'd0);
        check("rst_tx_data", bus.tx_data, 32'd0);
        check("rst_toggle", 32'(bus.tx_req_toggle), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask
    task automatic wait_done(input string tag);
        int n = 0;
        logic got = 1'b0;
        while (!got && n < 20) begin
            step(1'b0, $urandom);
            n++;
            got = bus.done;
        end
        check(tag, n, 32'd4);
    endtask
    initial begin
        int n = 0;
        int n2 = 0;
        bus.en = 1'b0;
        bus.din = '0;
        do_reset();
        step(1'b1, 32'hDEADBEEF);
        check("t1_data", bus.tx_data, 32'hDEADBEEF);
        check("t1_toggle", 32'(bus.tx_req_toggle), 32'd1);
        check("t1_busy", 32'(bus.busy), 32'd1);
        step(1'b1, 32'h1111);
        check("t2_dropped", 32'(bus.dropped), 32'd1);
        check("t2_data", bus.tx_data, 32'hDEADBEEF);
        check("t2_toggle", 32'(bus.tx_req_toggle), 32'd1);
        repeat (4) step(1'b0, $urandom);
        ack_man = 1'b1;
        wait_done("t1_done_latency");
        step(1'b0, $urandom);
        check("t1_idle", 32'(bus.busy), 32'd0);
        step(1'b1, 32'h2222);
        check("t3_toggle", 32'(bus.tx_req_toggle), 32'd0);
        check("t3_data", bus.tx_data, 32'h2222);
        repeat (3) step(1'b0, $urandom);
        ack_man = 1'b0;
        wait_done("t3_done_latency");
        step(1'b1, 32'h3333);
        check("t4_dropped", 32'(bus.dropped), 32'd1);
        check("t4_busy", 32'(bus.busy), 32'd0);
        step(1'b0, 32'h0);
        check("t4_toggle", 32'(bus.tx_req_toggle), 32'd0);
        check("t4_data", bus.tx_data, 32'h2222);
        step(1'b1, 32'h4444);
        check("t5_busy", 32'(bus.busy), 32'd1);
        ack_man = 1'b1;
        do_reset();
        repeat (4) step(1'b0, $urandom);
        step(1'b1, 32'h5555);
        check("t5_stale_drop", 32'(bus.dropped), 32'd1);
        step(1'b1, 32'h6666);
        check("t5_stale_drop2", 32'(bus.dropped), 32'd1);
        ack_man = 1'b0;
        repeat (4) step(1'b0, $urandom);
        step(1'b1, 32'h7777);
        check("t5_accept_toggle", 32'(bus.tx_req_toggle), 32'd1);
        check("t5_accept_data", bus.tx_data, 32'h7777);
        repeat (2) step(1'b0, $urandom);
        ack_man = 1'b1;
        wait_done("t5_done_latency");
        ack_man = 1'b0;
        auto_mode = 1'b1;
        do_reset();
        q_exp.delete();
        while (sent < 1000 && n < 40000) begin
            step(1'($urandom_range(0, 1)), $urandom);
            n++;
        end
        while (((sent != acked) || just_done) && n2 < 200) begin
            step(1'b0, $urandom);
            n2++;
        end
        repeat (10) step(1'b0, $urandom);
        check("soak_timeout", 32'(n < 40000 && n2 < 200), 32'd1);
        check("soak_words", q_rx.size(), q_exp.size());
        for (int i = 0; i < q_exp.size() && i < q_rx.size(); i++) check("soak_word", q_rx[i], q_exp[i]);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
